agc_counter_steal: RTL and testbench

- Services AGC involuntary counters (TIME1, TIME2 and similar) by stealing memory cycles from the instruction sequencer at instruction boundaries.
- Latches PINC/MINC requests from timers and peripherals, then arbitrates among pending counters.
- Runs a read-modify-write on the erasable word using 15-bit ones'-complement arithmetic.
- Holds off the control-pulse sequencer while it owns the memory port.

---
 rtl/agc_counter_steal.sv | 192 +++++++++++++++++++
 tb/tb_agc_counter_steal.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_counter_steal.sv
// AGC involuntary-counter service: latches PINC/MINC requests, steals memory
// cycles at instruction boundaries and runs a ones'-complement read-modify-write.

module agc_ctr_pend (
  input  logic clk,
  input  logic rst_n,
  input  logic pinc,
  input  logic minc,
  input  logic clr,
  output logic pend,
  output logic dir,
  output logic pend_nxt,
  output logic dir_nxt,
  output logic drop
);
  logic base;

  // A clear from the write cycle happens first, so a same-cycle request re-arms.
  always_comb begin
    base     = pend & ~clr;
    pend_nxt = base;
    dir_nxt  = dir;
    drop     = 1'b0;
    if (pinc ^ minc) begin
      if (!base) begin
        pend_nxt = 1'b1;
        dir_nxt  = pinc;
      end else if (dir == pinc) begin
        drop = 1'b1;
      end else begin
        pend_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      dir  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      dir  <= dir_nxt;
    end
  end
endmodule

module agc_counter_steal #(
  parameter int                   NUM_CTR    = 4,
  parameter int                   ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = 12'o0024,
  parameter logic [NUM_CTR-1:0]   CHAIN_MASK = 4'b0010,
  parameter int                   MAX_BURST  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CTR-1:0] pinc_req,
  input  logic [NUM_CTR-1:0] minc_req,
  input  logic               cpu_at_boundary,
  output logic               cpu_hold,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [14:0]        mem_wdata,
  input  logic [14:0]        mem_rdata,
  output logic [NUM_CTR-1:0] ovf_pulse,
  output logic               drop_err,
  output logic               busy
);
  localparam int CW = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_t;
  typedef struct packed {
    logic [14:0] data;
    logic        ovf;
  } upd_t;

  // AGC counters saturate into the zero of the step direction on overflow.
  function automatic upd_t ones_step(input logic [14:0] d, input logic up);
    upd_t r;
    r.ovf = 1'b0;
    if (up) begin
      if (d == 15'o37777) begin
        r.data = 15'o00000;
        r.ovf  = 1'b1;
      end else if (d == 15'o77777) r.data = 15'o00001;
      else r.data = d + 15'd1;
    end else begin
      if (d == 15'o40000) begin
        r.data = 15'o77777;
        r.ovf  = 1'b1;
      end else if (d == 15'o00000) r.data = 15'o77776;
      else r.data = d - 15'd1;
    end
    return r;
  endfunction

  state_t             state, state_nxt;
  logic [CW-1:0]      k_q, sel_idx;
  logic               up_q, sel_dir, sel_any, load;
  logic [BW-1:0]      burst_q, burst_nxt;
  upd_t               upd_q;
  logic               in_write, ovf_fire;
  logic [NUM_CTR-1:0] pend, dir, pend_nxt, dir_nxt, drop, clr, chain, sel_vec, dir_src;

  assign in_write = (state == WRITE);
  assign ovf_fire = in_write & upd_q.ovf;

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    assign clr[i]       = in_write & (k_q == CW'(i));
    assign ovf_pulse[i] = ovf_fire & (k_q == CW'(i));
    if (i < NUM_CTR - 1) begin : g_chain
      assign chain[i] = ovf_fire & CHAIN_MASK[i+1] & (k_q == CW'(i + 1));
    end else begin : g_nochain
      assign chain[i] = 1'b0;
    end
    agc_ctr_pend u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .pinc     (pinc_req[i] | chain[i]),
      .minc     (minc_req[i]),
      .clr      (clr[i]),
      .pend     (pend[i]),
      .dir      (dir[i]),
      .pend_nxt (pend_nxt[i]),
      .dir_nxt  (dir_nxt[i]),
      .drop     (drop[i])
    );
  end

  // Burst reselection looks at next-cycle pends so a freshly chained PINC is seen.
  assign sel_vec = in_write ? pend_nxt : pend;
  assign dir_src = in_write ? dir_nxt  : dir;
  assign sel_any = |sel_vec;
  assign sel_dir = dir_src[sel_idx];

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CTR - 1; i >= 0; i--)
      if (sel_vec[i]) sel_idx = CW'(i);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    burst_nxt = burst_q;
    case (state)
      IDLE: if (cpu_at_boundary && sel_any) begin
        state_nxt = READ;
        load      = 1'b1;
        burst_nxt = BW'(1);
      end
      READ:   state_nxt = MODIFY;
      MODIFY: state_nxt = WRITE;
      WRITE: begin
        if (sel_any && (burst_q < BW'(MAX_BURST))) begin
          state_nxt = READ;
          load      = 1'b1;
          burst_nxt = burst_q + BW'(1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_q      <= '0;
      up_q     <= 1'b0;
      burst_q  <= '0;
      upd_q    <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      burst_q  <= burst_nxt;
      drop_err <= drop_err | (|drop);
      if (load) begin
        k_q  <= sel_idx;
        up_q <= sel_dir;
      end
      if (state == MODIFY) upd_q <= ones_step(mem_rdata, up_q);
    end
  end

  assign busy      = (state != IDLE);
  assign cpu_hold  = busy | ((|pend) & cpu_at_boundary);
  assign mem_addr  = busy ? BASE_ADDR + ADDR_W'(k_q) : '0;
  assign mem_we    = in_write;
  assign mem_wdata = in_write ? upd_q.data : 15'o0;
endmodule

// File: tb/tb_agc_counter_steal.sv
// Bench for agc_counter_steal: value-level ones'-complement model, per-cycle
// output compare, plus hand-computed memory and timing expectations.

module tb_agc_counter_steal;
  localparam int         N     = 4;
  localparam logic [3:0] CHAIN = 4'b0010;
  localparam int         MAXB  = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] pinc_req = '0, minc_req = '0;
  logic        bnd = 1'b0;
  logic        cpu_hold, mem_we, drop_err, busy;
  logic [11:0] mem_addr;
  logic [14:0] mem_wdata, mem_rdata;
  logic [N-1:0] ovf_pulse;

  always #5 clk = ~clk;

  agc_counter_steal dut (
    .clk(clk), .rst_n(rst_n), .pinc_req(pinc_req), .minc_req(minc_req),
    .cpu_at_boundary(bnd), .cpu_hold(cpu_hold), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ovf_pulse(ovf_pulse), .drop_err(drop_err), .busy(busy)
  );

  // memory seen by the DUT, with a preload port for the bench
  logic [14:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [1:0]  pl_idx = '0;
  logic [14:0] pl_val = '0;
  always @(posedge clk) begin
    if (pl_en) mem[12'o24 + 12'(pl_idx)] <= pl_val;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_vec = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend, m_dir;
  logic         m_drop, m_up, m_ovf;
  int           m_ph, m_k, m_burst;   // m_ph: 0 idle, 1..3 = 1st..3rd stolen cycle
  logic [14:0]  m_res;
  logic [14:0]  m_mem [0:3];

  function automatic int lowest(input logic [N-1:0] p);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (p[i]) r = i;
    return r;
  endfunction

  // signed value arithmetic; a zero result keeps the sign of its operand
  function automatic logic [15:0] step(input logic [14:0] w, input logic up);
    int v;
    logic [14:0] r;
    logic o = 1'b0;
    v = w[14] ? -int'(~w & 15'h7fff) : int'(w);
    v = up ? v + 1 : v - 1;
    if (v > 16383) begin o = 1'b1; r = 15'o00000; end
    else if (v < -16383) begin o = 1'b1; r = 15'o77777; end
    else if (v == 0) r = w[14] ? 15'o77777 : 15'o00000;
    else if (v < 0) r = ~15'(-v);
    else r = 15'(v);
    return {r, o};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] p, d, chain;
    int ph, k, burst;
    logic up, ovf, pi;
    logic [14:0] res;
    if (!rst_n) begin
      m_pend <= '0; m_dir <= '0; m_drop <= 1'b0; m_ph <= 0; m_k <= 0;
      m_up <= 1'b0; m_burst <= 0; m_res <= '0; m_ovf <= 1'b0;
    end else begin
      p = m_pend; d = m_dir; chain = '0; ph = m_ph; k = m_k; up = m_up;
      burst = m_burst; res = m_res; ovf = m_ovf;
      if (pl_en) m_mem[pl_idx] <= pl_val;
      case (m_ph)
        0: if (bnd && p != 0) begin k = lowest(p); up = d[k]; burst = 1; ph = 1; end
        1: ph = 2;
        2: begin {res, ovf} = step(m_mem[k], up); ph = 3; end
        default: begin
          m_mem[k] <= res;
          p[k] = 1'b0;
          if (ovf && CHAIN[k] && k > 0) chain[k-1] = 1'b1;
        end
      endcase
      for (int i = 0; i < N; i++) begin
        pi = pinc_req[i] | chain[i];
        if (pi != minc_req[i]) begin
          if (!p[i]) begin p[i] = 1'b1; d[i] = pi; end
          else if (d[i] == pi) m_drop <= 1'b1;
          else p[i] = 1'b0;
        end
      end
      if (m_ph == 3) begin
        if (p != 0 && burst < MAXB) begin k = lowest(p); up = d[k]; burst++; ph = 1; end
        else ph = 0;
      end
      m_pend <= p; m_dir <= d; m_ph <= ph; m_k <= k; m_up <= up;
      m_burst <= burst; m_res <= res; m_ovf <= ovf;
    end
  end

  // ---------------- per-cycle compare ----------------
  int busy_cnt = 0, ovf_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    logic e_busy, e_we;
    e_busy = (m_ph != 0);
    e_we   = (m_ph == 3);
    check("busy", 32'(busy), 32'(e_busy));
    check("cpu_hold", 32'(cpu_hold), 32'(e_busy || (m_pend != 0 && bnd)));
    check("mem_addr", 32'(mem_addr), e_busy ? 32'(12'o24 + m_k) : 32'd0);
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_wdata", 32'(mem_wdata), e_we ? 32'(m_res) : 32'd0);
    check("ovf_pulse", 32'(ovf_pulse), (e_we && m_ovf) ? (32'd1 << m_k) : 32'd0);
    check("drop_err", 32'(drop_err), 32'(m_drop));
    if (busy) busy_cnt++;
    if (ovf_pulse != 0) ovf_cnt++;
    if (mem_we) wr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [1:0] idx, input logic [14:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    tick(1);
    pl_en = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] pv, input logic [N-1:0] mv);
    pinc_req = pv; minc_req = mv;
    tick(1);
    pinc_req = '0; minc_req = '0;
  endtask

  initial begin
    int b0, o0, w0;
    bit seen;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_hold", 32'(cpu_hold), 0);
    check("rst_drop", 32'(drop_err), 0);
    rst_n = 1'b1;
    tick(1);

    // basic increment
    preload(2'd1, 15'o000005);
    bnd = 1'b1; b0 = busy_cnt;
    pulse(4'b0010, 4'b0000);
    tick(8);
    check("inc_mem025", 32'(mem[12'o25]), 32'o6);
    check("inc_busy_cycles", 32'(busy_cnt - b0), 3);

    // overflow chain into counter 0 within one steal
    preload(2'd1, 15'o037777);
    preload(2'd0, 15'o000010);
    b0 = busy_cnt; o0 = ovf_cnt;
    pulse(4'b0010, 4'b0000);
    tick(12);
    check("chain_mem025", 32'(mem[12'o25]), 32'o0);
    check("chain_mem024", 32'(mem[12'o24]), 32'o11);
    check("chain_busy_cycles", 32'(busy_cnt - b0), 6);
    check("chain_ovf_count", 32'(ovf_cnt - o0), 1);

    // zero edges
    o0 = ovf_cnt;
    preload(2'd1, 15'o077777);
    pulse(4'b0010, 4'b0000);
    tick(8);
    check("pinc_negzero", 32'(mem[12'o25]), 32'o1);
    preload(2'd2, 15'o000000);
    pulse(4'b0000, 4'b0100);
    tick(8);
    check("minc_poszero", 32'(mem[12'o26]), 32'o77776);
    check("zero_no_ovf", 32'(ovf_cnt - o0), 0);
    preload(2'd3, 15'o040000);
    pulse(4'b0000, 4'b1000);
    tick(8);
    check("minc_ovf_mem", 32'(mem[12'o27]), 32'o77777);
    check("minc_ovf_count", 32'(ovf_cnt - o0), 1);

    // cancel then drop
    bnd = 1'b0; w0 = wr_cnt;
    pulse(4'b0100, 4'b0000);
    pulse(4'b0000, 4'b0100);
    bnd = 1'b1;
    tick(6);
    check("cancel_writes", 32'(wr_cnt - w0), 0);
    check("cancel_drop", 32'(drop_err), 0);
    bnd = 1'b0;
    preload(2'd2, 15'o000100);
    w0 = wr_cnt;
    pulse(4'b0100, 4'b0000);
    pulse(4'b0100, 4'b0000);
    bnd = 1'b1;
    tick(8);
    check("drop_mem026", 32'(mem[12'o26]), 32'o101);
    check("drop_writes", 32'(wr_cnt - w0), 1);
    check("drop_err_set", 32'(drop_err), 1);

    // arbitration and burst limit
    bnd = 1'b0;
    preload(2'd0, 15'o0); preload(2'd2, 15'o0); preload(2'd3, 15'o0);
    pulse(4'b1101, 4'b0000);
    b0 = busy_cnt;
    bnd = 1'b1;
    tick(1);
    bnd = 1'b0;
    tick(10);
    check("arb_busy_first", 32'(busy_cnt - b0), 6);
    check("arb_mem024", 32'(mem[12'o24]), 32'o1);
    check("arb_mem026", 32'(mem[12'o26]), 32'o1);
    check("arb_mem027_wait", 32'(mem[12'o27]), 32'o0);
    bnd = 1'b1;
    tick(8);
    check("arb_mem027", 32'(mem[12'o27]), 32'o1);
    check("arb_busy_total", 32'(busy_cnt - b0), 9);

    // reset in the write cycle
    preload(2'd1, 15'o000200);
    pulse(4'b0010, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (mem_we) seen = 1'b1;
      else tick(1);
    end
    check("rst_write_reached", 32'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_we", 32'(mem_we), 0);
    check("rst_async_hold", 32'(cpu_hold), 0);
    check("rst_async_busy", 32'(busy), 0);
    tick(1);
    rst_n = 1'b1;
    w0 = wr_cnt;
    tick(6);
    check("rst_no_write", 32'(wr_cnt - w0), 0);
    check("rst_mem025", 32'(mem[12'o25]), 32'o200);
    check("rst_drop_clr", 32'(drop_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
